// File: rtl/multi_fifo_bank_if.sv
// Write/read handshake bundle shared by the FIFO bank and whoever drives it.
// The master side issues requests; the slave side is the bank itself.
interface multi_fifo_bank_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/multi_fifo_bank.sv
// Bank of NUM_CH independent circular FIFOs, either addressed per request (MODE 0)
// or walked line-by-line in ping-pong order (MODE 1), with sticky error flags.
module multi_fifo_bank #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int NUM_CH   = 2,
    parameter int LINE_LEN = 8,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_fifo_bank_if.slave          bus,
    output logic [NUM_CH-1:0]         full,
    output logic [NUM_CH-1:0]         empty,
    output logic [$clog2(NUM_CH)-1:0] cur_wr_ch,
    output logic [$clog2(NUM_CH)-1:0] cur_rd_ch,
    input  logic                      err_clr,
    output logic                      err_ovf,
    output logic                      err_udf,
    output logic                      err_ch
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LC_W  = $clog2(LINE_LEN + 1);

    localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [LC_W-1:0]  LINE_LAST  = LC_W'(LINE_LEN - 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

    logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];

    logic [CH_W-1:0]   wr_sel, rd_sel;
    logic [LC_W-1:0]   wr_line, rd_line;
    logic [CH_W-1:0]   wr_tgt, rd_src;
    logic              wr_ch_ok, rd_ch_ok, tgt_full, src_empty;
    logic              wr_acc, rd_acc;
    logic              ovf_set, udf_set, ch_set;
    logic [NUM_CH-1:0] wr_hit, rd_hit;

    // Status comes only from registered counts, so a read never frees room for a same-cycle write.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
        end
    end

    always_comb begin
        wr_tgt    = (MODE == 1) ? wr_sel : bus.wr_ch;
        rd_src    = (MODE == 1) ? rd_sel : bus.rd_ch;
        wr_ch_ok  = ({1'b0, wr_tgt} < NUM_CH_EXT);
        rd_ch_ok  = ({1'b0, rd_src} < NUM_CH_EXT);
        tgt_full  = 1'b0;
        src_empty = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_tgt == CH_W'(i)) tgt_full  = full[i];
            if (rd_src == CH_W'(i)) src_empty = empty[i];
        end
        wr_acc       = bus.wr_en && wr_ch_ok && !tgt_full;
        rd_acc       = bus.rd_en && rd_ch_ok && !src_empty;
        ovf_set      = bus.wr_en && wr_ch_ok && tgt_full;
        udf_set      = bus.rd_en && rd_ch_ok && src_empty;
        ch_set       = (bus.wr_en && !wr_ch_ok) || (bus.rd_en && !rd_ch_ok);
        bus.wr_ready = wr_ch_ok && !tgt_full;
        cur_wr_ch    = wr_tgt;
        cur_rd_ch    = rd_src;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_acc && (wr_tgt == CH_W'(i));
            rd_hit[i] = rd_acc && (rd_src == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst && wr_hit[i]) mem[i][wr_ptr[i]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (rd_hit[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({wr_hit[i], rd_hit[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // rd_data only moves on an accepted read; otherwise it keeps the last word delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rd_acc;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_hit[i]) bus.rd_data <= mem[i][rd_ptr[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel  <= '0;
            rd_sel  <= '0;
            wr_line <= '0;
            rd_line <= '0;
        end else if (MODE == 1) begin
            if (wr_acc) begin
                if (wr_line == LINE_LAST) begin
                    wr_line <= '0;
                    wr_sel  <= (wr_sel == LAST_CH) ? '0 : wr_sel + CH_W'(1);
                end else begin
                    wr_line <= wr_line + LC_W'(1);
                end
            end
            if (rd_acc) begin
                if (rd_line == LINE_LAST) begin
                    rd_line <= '0;
                    rd_sel  <= (rd_sel == LAST_CH) ? '0 : rd_sel + CH_W'(1);
                end else begin
                    rd_line <= rd_line + LC_W'(1);
                end
            end
        end
    end

    // A fresh error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
            err_ch  <= 1'b0;
        end else begin
            err_ovf <= ovf_set || (err_ovf && !err_clr);
            err_udf <= udf_set || (err_udf && !err_clr);
            err_ch  <= ch_set  || (err_ch  && !err_clr);
        end
    end
endmodule

// File: tb/tb_multi_fifo_bank.sv
// Bench for multi_fifo_bank: an addressed 3-channel bank and a ping-pong 2-channel bank
// driven side by side and compared every cycle against queue-based reference models.
module tb_multi_fifo_bank;
    localparam int DEPTH = 16;
    localparam int LINE  = 8;

    typedef logic [15:0] wq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr0 = 1'b0;
    logic clr1 = 1'b0;

    always #5 clk = ~clk;

    multi_fifo_bank_if #(.DATA_W(16), .NUM_CH(3)) b0 ();
    multi_fifo_bank_if #(.DATA_W(16), .NUM_CH(2)) b1 ();

    logic [2:0] full0, empty0;
    logic [1:0] cw0, cr0;
    logic       ovf0, udf0, ech0;
    logic [1:0] full1, empty1;
    logic       cw1, cr1;
    logic       ovf1, udf1, ech1;

    multi_fifo_bank #(.DATA_W(16), .DEPTH(DEPTH), .NUM_CH(3), .LINE_LEN(LINE), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .full(full0), .empty(empty0),
        .cur_wr_ch(cw0), .cur_rd_ch(cr0), .err_clr(clr0),
        .err_ovf(ovf0), .err_udf(udf0), .err_ch(ech0)
    );

    multi_fifo_bank #(.DATA_W(16), .DEPTH(DEPTH), .NUM_CH(2), .LINE_LEN(LINE), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .full(full1), .empty(empty1),
        .cur_wr_ch(cw1), .cur_rd_ch(cr1), .err_clr(clr1),
        .err_ovf(ovf1), .err_udf(udf1), .err_ch(ech1)
    );

    // Reference model: channels 0..2 of unit 0 live in mq[0..2], channels 0..1 of unit 1 in mq[3..4].
    wq_t         mq [5];
    logic        e_ovf [2];
    logic        e_udf [2];
    logic        e_ch  [2];
    logic        e_rv  [2];
    logic [15:0] e_rd  [2];
    int          w_sel, r_sel, w_cnt, r_cnt;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] ef0, ee0;
        logic [1:0] ef1, ee1;
        for (int c = 0; c < 3; c++) begin
            ef0[c] = (mq[c].size() == DEPTH);
            ee0[c] = (mq[c].size() == 0);
        end
        for (int c = 0; c < 2; c++) begin
            ef1[c] = (mq[3+c].size() == DEPTH);
            ee1[c] = (mq[3+c].size() == 0);
        end
        chk("rd_valid0", b0.rd_valid, e_rv[0]);
        chk("rd_data0",  b0.rd_data,  e_rd[0]);
        chk("full0",     full0,       ef0);
        chk("empty0",    empty0,      ee0);
        chk("err_ovf0",  ovf0,        e_ovf[0]);
        chk("err_udf0",  udf0,        e_udf[0]);
        chk("err_ch0",   ech0,        e_ch[0]);
        chk("rd_valid1", b1.rd_valid, e_rv[1]);
        chk("rd_data1",  b1.rd_data,  e_rd[1]);
        chk("full1",     full1,       ef1);
        chk("empty1",    empty1,      ee1);
        chk("err_ovf1",  ovf1,        e_ovf[1]);
        chk("err_udf1",  udf1,        e_udf[1]);
        chk("err_ch1",   ech1,        e_ch[1]);
        chk("cur_wr1",   cw1,         w_sel);
        chk("cur_rd1",   cr1,         r_sel);
    endtask

    task automatic idleInputs();
        b0.wr_en = 1'b0; b0.wr_ch = '0; b0.wr_data = '0; b0.rd_en = 1'b0; b0.rd_ch = '0;
        b1.wr_en = 1'b0; b1.wr_ch = '0; b1.wr_data = '0; b1.rd_en = 1'b0; b1.rd_ch = '0;
        clr0 = 1'b0;
        clr1 = 1'b0;
    endtask

    // One clock of traffic on the chosen unit; the other unit sits idle.
    task automatic applyStimulus(input int unit, input logic we, input logic [1:0] wch,
                                 input logic [15:0] wd, input logic re, input logic [1:0] rch,
                                 input logic clr);
        int base, nch, wt, rs;
        logic wok, rok, wfull, rempty, wacc, racc;
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        if (unit == 0) begin
            b0.wr_en = we; b0.wr_ch = wch; b0.wr_data = wd; b0.rd_en = re; b0.rd_ch = rch;
            clr0 = clr;
        end else begin
            b1.wr_en = we; b1.wr_ch = wch[0]; b1.wr_data = wd; b1.rd_en = re; b1.rd_ch = rch[0];
            clr1 = clr;
        end
        #1;
        base = (unit == 0) ? 0 : 3;
        nch  = (unit == 0) ? 3 : 2;
        wt   = (unit == 0) ? int'(wch) : w_sel;
        rs   = (unit == 0) ? int'(rch) : r_sel;
        wok  = (wt < nch);
        rok  = (rs < nch);
        wfull  = 1'b0;
        rempty = 1'b0;
        if (wok) wfull  = (mq[base+wt].size() == DEPTH);
        if (rok) rempty = (mq[base+rs].size() == 0);
        if (unit == 0) begin
            chk("wr_ready0", b0.wr_ready, wok && !wfull);
            chk("cur_wr0", cw0, wch);
            chk("cur_rd0", cr0, rch);
        end else begin
            chk("wr_ready1", b1.wr_ready, wok && !wfull);
        end
        wacc = we && wok && !wfull;
        racc = re && rok && !rempty;
        e_ovf[unit] = (we && wok && wfull) || (e_ovf[unit] && !clr);
        e_udf[unit] = (re && rok && rempty) || (e_udf[unit] && !clr);
        e_ch[unit]  = (we && !wok) || (re && !rok) || (e_ch[unit] && !clr);
        e_rv[0] = 1'b0;
        e_rv[1] = 1'b0;
        if (racc) begin
            e_rv[unit] = 1'b1;
            e_rd[unit] = mq[base+rs].pop_front();
        end
        if (wacc) mq[base+wt].push_back(wd);
        if (unit == 1) begin
            if (wacc) begin
                w_cnt++;
                if (w_cnt == LINE) begin w_cnt = 0; w_sel = (w_sel + 1) % 2; end
            end
            if (racc) begin
                r_cnt++;
                if (r_cnt == LINE) begin r_cnt = 0; r_sel = (r_sel + 1) % 2; end
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset with live requests on both units to show reset wins over them.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        b0.wr_en = 1'b1; b0.wr_ch = 2'd0; b0.wr_data = 16'h5A5A; b0.rd_en = 1'b1; b0.rd_ch = 2'd0;
        b1.wr_en = 1'b1; b1.wr_data = 16'hA5A5; b1.rd_en = 1'b1;
        @(posedge clk);
        #1;
        for (int q = 0; q < 5; q++) mq[q].delete();
        for (int u = 0; u < 2; u++) begin
            e_ovf[u] = 1'b0; e_udf[u] = 1'b0; e_ch[u] = 1'b0; e_rv[u] = 1'b0; e_rd[u] = '0;
        end
        w_sel = 0; r_sel = 0; w_cnt = 0; r_cnt = 0;
        checkOutput();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] first_word;
        idleInputs();
        doReset();
        chk("reset_empty0", empty0, 3'b111);
        chk("reset_full1", full1, 2'b00);

        for (int i = 1; i <= 16; i++) applyStimulus(0, 1'b1, 2'd0, 16'(i), 1'b0, 2'd0, 1'b0);
        chk("fill_full0", full0[0], 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);
        chk("last_read0", b0.rd_data, 16'h0010);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        chk("drain_empty0", empty0[0], 1'b1);
        chk("hold_data0", b0.rd_data, 16'h0010);

        first_word = 16'($urandom);
        applyStimulus(0, 1'b1, 2'd1, first_word, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i < 16; i++) applyStimulus(0, 1'b1, 2'd1, 16'($urandom), 1'b0, 2'd0, 1'b0);
        applyStimulus(0, 1'b1, 2'd1, 16'hBEEF, 1'b0, 2'd0, 1'b0);
        chk("ovf_set0", ovf0, 1'b1);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b0);
        chk("ovf_first_word", b0.rd_data, first_word);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b0);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);

        applyStimulus(0, 1'b1, 2'd0, 16'h00AA, 1'b1, 2'd0, 1'b0);
        chk("nobypass_rv", b0.rd_valid, 1'b0);
        chk("nobypass_udf", udf0, 1'b1);
        chk("nobypass_stored", empty0[0], 1'b0);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b1);
        chk("nobypass_data", b0.rd_data, 16'h00AA);

        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b1, 2'd0, 16'(16'h100 + i), 1'b0, 2'd0, 1'b0);
        applyStimulus(0, 1'b1, 2'd0, 16'hDEAD, 1'b1, 2'd0, 1'b0);
        chk("fullrw_ovf", ovf0, 1'b1);
        chk("fullrw_notfull", full0[0], 1'b0);
        chk("fullrw_data", b0.rd_data, 16'h0100);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
        chk("clr_ovf", ovf0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);

        applyStimulus(0, 1'b1, 2'd3, 16'h1234, 1'b0, 2'd0, 1'b0);
        chk("badch_set", ech0, 1'b1);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b1, 2'd3, 1'b1);
        chk("badch_clr_collide", ech0, 1'b1);
        applyStimulus(0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
        chk("badch_clr", ech0, 1'b0);

        for (int i = 0; i < 24; i++) applyStimulus(1, 1'b1, 2'd0, 16'(i), 1'b0, 2'd0, 1'b0);
        chk("pp_full", full1, 2'b01);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1, 1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);
            chk("pp_order", b1.rd_data, 16'(i));
        end

        for (int i = 0; i < 5; i++) applyStimulus(1, 1'b1, 2'd0, 16'(16'h200 + i), 1'b0, 2'd0, 1'b0);
        doReset();
        chk("midline_sel", cw1, 1'b0);
        chk("midline_empty", empty1, 2'b11);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 2'd0, 16'(16'h300 + i), 1'b0, 2'd0, 1'b0);
        chk("midline_ch0", empty1, 2'b10);
        chk("midline_adv", cw1, 1'b1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                applyStimulus(int'($urandom_range(0, 1)), ($urandom_range(0, 99) < 55),
                              2'($urandom_range(0, 3)), 16'($urandom),
                              ($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)),
                              ($urandom_range(0, 9) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
